// File: rtl/rs_pkg.sv
// Shared types and default widths for the unified reservation station.
package rs_pkg;

    localparam int RS_TAG_W = 6;
    localparam int RS_XLEN  = 32;

    typedef enum logic [1:0] {
        FU_ALU = 2'd0,
        FU_LSU = 2'd1,
        FU_MUL = 2'd2
    } fu_class_t;

    typedef struct packed {
        logic [RS_XLEN-1:0]  pc;
        logic [RS_XLEN-1:0]  inst;
        logic [RS_TAG_W-1:0] prs1;
        logic [RS_TAG_W-1:0] prs2;
        logic [RS_TAG_W-1:0] prd;
        fu_class_t           fu;
    } rs_payload_t;

endpackage

// File: rtl/rs_oldest_sel.sv
// Oldest-first picker: grants the requester that no other requester is older than.
module rs_oldest_sel #(
    parameter  int N     = 8,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]        req_i,
    input  logic [N-1:0][N-1:0] age_i,
    output logic [N-1:0]        gnt_o,
    output logic [IDX_W-1:0]    idx_o
);

    logic [N-1:0] older;

    // age_i[j][i]=1 means j is older than i; the age order is total over valid entries,
    // so at most one requester survives.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        older = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                older[j] = (j != i) && req_i[j] && age_i[j][i];
            end
            gnt_o[i] = req_i[i] && !(|older);
        end
        for (int i = 0; i < N; i++) begin
            if (gnt_o[i]) idx_o = IDX_W'(i);
        end
    end

endmodule

// File: rtl/rs_multi_fu.sv
// Unified reservation station: shared entry pool, CDB wakeup with allocation bypass,
// and oldest-ready issue per FU class through valid/ready ports.
module rs_multi_fu
    import rs_pkg::*;
#(
    parameter  int RS_DEPTH = 8,
    parameter  int NUM_FU   = 3,
    parameter  int TAG_W    = RS_TAG_W,
    parameter  int XLEN     = RS_XLEN,
    localparam int FU_W     = $clog2(NUM_FU),
    localparam int CNT_W    = $clog2(RS_DEPTH + 1)
) (
    input  logic                    clk_i,
    input  logic                    reset_ni,
    input  logic                    flush_i,
    input  logic                    alloc_valid_i,
    output logic                    alloc_ready_o,
    input  logic [FU_W-1:0]         alloc_fu_i,
    input  logic [XLEN-1:0]         alloc_pc_i,
    input  logic [XLEN-1:0]         alloc_inst_i,
    input  logic [TAG_W-1:0]        alloc_prs1_i,
    input  logic [TAG_W-1:0]        alloc_prs2_i,
    input  logic [TAG_W-1:0]        alloc_prd_i,
    input  logic                    alloc_rdy1_i,
    input  logic                    alloc_rdy2_i,
    input  logic                    cdb_en_i,
    input  logic [TAG_W-1:0]        cdb_tag_i,
    output logic [NUM_FU-1:0]       iss_valid_o,
    input  logic [NUM_FU-1:0]       iss_ready_i,
    output logic [NUM_FU*XLEN-1:0]  iss_pc_o,
    output logic [NUM_FU*XLEN-1:0]  iss_inst_o,
    output logic [NUM_FU*TAG_W-1:0] iss_prs1_o,
    output logic [NUM_FU*TAG_W-1:0] iss_prs2_o,
    output logic [NUM_FU*TAG_W-1:0] iss_prd_o,
    output logic [CNT_W-1:0]        count_o
);

    localparam int IDX_W = $clog2(RS_DEPTH);

    logic [RS_DEPTH-1:0]               valid_q, rdy1_q, rdy2_q;
    logic [RS_DEPTH-1:0][RS_DEPTH-1:0] age_q;
    logic [FU_W-1:0]                   fu_q   [RS_DEPTH];
    logic [XLEN-1:0]                   pc_q   [RS_DEPTH];
    logic [XLEN-1:0]                   inst_q [RS_DEPTH];
    logic [TAG_W-1:0]                  prs1_q [RS_DEPTH];
    logic [TAG_W-1:0]                  prs2_q [RS_DEPTH];
    logic [TAG_W-1:0]                  prd_q  [RS_DEPTH];

    logic [RS_DEPTH-1:0] ent_rdy, iss_free, wake1, wake2, alloc_oh;
    logic [RS_DEPTH-1:0] fired_gnt [NUM_FU];
    logic [IDX_W-1:0]    alloc_idx;
    logic                alloc_fire, byp1, byp2;

    // Occupancy is registered only, so a slot freed by issue this cycle is not reused yet.
    assign alloc_ready_o = ~&valid_q;
    assign count_o       = CNT_W'($countones(valid_q));
    assign ent_rdy       = valid_q & rdy1_q & rdy2_q;
    assign alloc_fire    = alloc_valid_i && alloc_ready_o && !flush_i && (int'(alloc_fu_i) < NUM_FU);
    assign alloc_oh      = alloc_fire ? (RS_DEPTH'(1) << alloc_idx) : '0;
    assign byp1          = cdb_en_i && (cdb_tag_i == alloc_prs1_i);
    assign byp2          = cdb_en_i && (cdb_tag_i == alloc_prs2_i);

    always_comb begin
        alloc_idx = '0;
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (!valid_q[i]) alloc_idx = IDX_W'(i);
        end
    end

    always_comb begin
        wake1 = '0;
        wake2 = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            wake1[i] = cdb_en_i && (prs1_q[i] == cdb_tag_i);
            wake2[i] = cdb_en_i && (prs2_q[i] == cdb_tag_i);
        end
    end

    for (genvar f = 0; f < NUM_FU; f++) begin : g_fu
        logic [RS_DEPTH-1:0] req, gnt;
        logic [IDX_W-1:0]    idx;

        always_comb begin
            req = '0;
            for (int i = 0; i < RS_DEPTH; i++) begin
                req[i] = ent_rdy[i] && (fu_q[i] == FU_W'(f));
            end
        end

        rs_oldest_sel #(.N(RS_DEPTH)) u_sel (
            .req_i (req),
            .age_i (age_q),
            .gnt_o (gnt),
            .idx_o (idx)
        );

        assign iss_valid_o[f] = |req;
        assign fired_gnt[f]   = (iss_valid_o[f] && iss_ready_i[f]) ? gnt : '0;

        assign iss_pc_o  [f*XLEN  +: XLEN]  = iss_valid_o[f] ? pc_q[idx]   : '0;
        assign iss_inst_o[f*XLEN  +: XLEN]  = iss_valid_o[f] ? inst_q[idx] : '0;
        assign iss_prs1_o[f*TAG_W +: TAG_W] = iss_valid_o[f] ? prs1_q[idx] : '0;
        assign iss_prs2_o[f*TAG_W +: TAG_W] = iss_valid_o[f] ? prs2_q[idx] : '0;
        assign iss_prd_o [f*TAG_W +: TAG_W] = iss_valid_o[f] ? prd_q[idx]  : '0;
    end

    always_comb begin
        iss_free = '0;
        for (int f = 0; f < NUM_FU; f++) iss_free |= fired_gnt[f];
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            valid_q <= '0;
            rdy1_q  <= '0;
            rdy2_q  <= '0;
            age_q   <= '0;
        end else if (flush_i) begin
            valid_q <= '0;
            age_q   <= '0;
        end else begin
            valid_q <= (valid_q & ~iss_free) | alloc_oh;
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (alloc_oh[i]) begin
                    rdy1_q[i] <= alloc_rdy1_i || byp1;
                    rdy2_q[i] <= alloc_rdy2_i || byp2;
                end else begin
                    if (wake1[i]) rdy1_q[i] <= 1'b1;
                    if (wake2[i]) rdy2_q[i] <= 1'b1;
                end
                // New entry is younger than everything: clear its row, set its column.
                for (int j = 0; j < RS_DEPTH; j++) begin
                    if (alloc_oh[i])      age_q[i][j] <= 1'b0;
                    else if (alloc_oh[j]) age_q[i][j] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (alloc_fire) begin
            fu_q[alloc_idx]   <= alloc_fu_i;
            pc_q[alloc_idx]   <= alloc_pc_i;
            inst_q[alloc_idx] <= alloc_inst_i;
            prs1_q[alloc_idx] <= alloc_prs1_i;
            prs2_q[alloc_idx] <= alloc_prs2_i;
            prd_q[alloc_idx]  <= alloc_prd_i;
        end
    end

    a_fu_legal: assert property (@(posedge clk_i) disable iff (!reset_ni)
        alloc_valid_i |-> (int'(alloc_fu_i) < NUM_FU));

endmodule

// File: tb/tb_rs_multi_fu.sv
// Bench for rs_multi_fu: directed scenarios plus random traffic against an in-order queue model.
module tb_rs_multi_fu;
    import rs_pkg::*;

    localparam int DEPTH = 8;
    localparam int NF    = 3;
    localparam int TW    = 6;
    localparam int XL    = 32;
    localparam int FUW   = 2;
    localparam int CW    = 4;

    logic             clk_i = 1'b0;
    logic             reset_ni = 1'b0;
    logic             flush_i, alloc_valid_i, alloc_ready_o;
    logic [FUW-1:0]   alloc_fu_i;
    logic [XL-1:0]    alloc_pc_i, alloc_inst_i;
    logic [TW-1:0]    alloc_prs1_i, alloc_prs2_i, alloc_prd_i, cdb_tag_i;
    logic             alloc_rdy1_i, alloc_rdy2_i, cdb_en_i;
    logic [NF-1:0]    iss_valid_o, iss_ready_i;
    logic [NF*XL-1:0] iss_pc_o, iss_inst_o;
    logic [NF*TW-1:0] iss_prs1_o, iss_prs2_o, iss_prd_o;
    logic [CW-1:0]    count_o;

    rs_multi_fu #(.RS_DEPTH(DEPTH), .NUM_FU(NF), .TAG_W(TW), .XLEN(XL)) dut (
        .clk_i(clk_i), .reset_ni(reset_ni), .flush_i(flush_i),
        .alloc_valid_i(alloc_valid_i), .alloc_ready_o(alloc_ready_o), .alloc_fu_i(alloc_fu_i),
        .alloc_pc_i(alloc_pc_i), .alloc_inst_i(alloc_inst_i),
        .alloc_prs1_i(alloc_prs1_i), .alloc_prs2_i(alloc_prs2_i), .alloc_prd_i(alloc_prd_i),
        .alloc_rdy1_i(alloc_rdy1_i), .alloc_rdy2_i(alloc_rdy2_i),
        .cdb_en_i(cdb_en_i), .cdb_tag_i(cdb_tag_i),
        .iss_valid_o(iss_valid_o), .iss_ready_i(iss_ready_i),
        .iss_pc_o(iss_pc_o), .iss_inst_o(iss_inst_o),
        .iss_prs1_o(iss_prs1_o), .iss_prs2_o(iss_prs2_o), .iss_prd_o(iss_prd_o),
        .count_o(count_o)
    );

    always #5 clk_i = ~clk_i;

    // Model: entries kept in allocation order, so queue position is age.
    typedef struct {
        int            fu;
        logic [XL-1:0] pc, inst;
        logic [TW-1:0] prs1, prs2, prd;
        bit            r1, r2;
    } ment_t;

    ment_t mq[$];
    int    n_checks = 0;
    int    n_errors = 0;

    task automatic check(input string tag, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int m_sel(input int f);
        for (int k = 0; k < mq.size(); k++)
            if (mq[k].fu == f && mq[k].r1 && mq[k].r2) return k;
        return -1;
    endfunction

    task automatic m_step();
        ment_t nq[$];
        ment_t ne;
        int    sel [NF];
        bit    do_alloc, gone;
        if (flush_i) begin
            mq.delete();
            return;
        end
        do_alloc = alloc_valid_i && (mq.size() < DEPTH) && (int'(alloc_fu_i) < NF);
        for (int f = 0; f < NF; f++) sel[f] = iss_ready_i[f] ? m_sel(f) : -1;
        for (int k = 0; k < mq.size(); k++) begin
            gone = 1'b0;
            for (int f = 0; f < NF; f++) if (sel[f] == k) gone = 1'b1;
            if (!gone) begin
                ne = mq[k];
                if (cdb_en_i && ne.prs1 == cdb_tag_i) ne.r1 = 1'b1;
                if (cdb_en_i && ne.prs2 == cdb_tag_i) ne.r2 = 1'b1;
                nq.push_back(ne);
            end
        end
        if (do_alloc) begin
            ne.fu   = int'(alloc_fu_i);
            ne.pc   = alloc_pc_i;
            ne.inst = alloc_inst_i;
            ne.prs1 = alloc_prs1_i;
            ne.prs2 = alloc_prs2_i;
            ne.prd  = alloc_prd_i;
            ne.r1   = alloc_rdy1_i || (cdb_en_i && cdb_tag_i == alloc_prs1_i);
            ne.r2   = alloc_rdy2_i || (cdb_en_i && cdb_tag_i == alloc_prs2_i);
            nq.push_back(ne);
        end
        mq = nq;
    endtask

    task automatic check_state();
        check("alloc_ready", alloc_ready_o, mq.size() < DEPTH);
        check("count", count_o, mq.size());
        for (int f = 0; f < NF; f++) begin
            int k;
            k = m_sel(f);
            check($sformatf("iss_valid[%0d]", f), iss_valid_o[f], k >= 0);
            if (k >= 0) begin
                check($sformatf("iss_pc[%0d]", f),   iss_pc_o[f*XL +: XL],   mq[k].pc);
                check($sformatf("iss_inst[%0d]", f), iss_inst_o[f*XL +: XL], mq[k].inst);
                check($sformatf("iss_prs1[%0d]", f), iss_prs1_o[f*TW +: TW], mq[k].prs1);
                check($sformatf("iss_prs2[%0d]", f), iss_prs2_o[f*TW +: TW], mq[k].prs2);
                check($sformatf("iss_prd[%0d]", f),  iss_prd_o[f*TW +: TW],  mq[k].prd);
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk_i);
        m_step();
        @(negedge clk_i);
        check_state();
    endtask

    task automatic idle_inputs();
        flush_i       = 1'b0;
        alloc_valid_i = 1'b0;
        cdb_en_i      = 1'b0;
        iss_ready_i   = '0;
    endtask

    task automatic set_alloc(input int fu, input int p1, input int p2, input int pd,
                             input bit r1, input bit r2);
        alloc_valid_i = 1'b1;
        alloc_fu_i    = FUW'(fu);
        alloc_pc_i    = $urandom;
        alloc_inst_i  = $urandom;
        alloc_prs1_i  = TW'(p1);
        alloc_prs2_i  = TW'(p2);
        alloc_prd_i   = TW'(pd);
        alloc_rdy1_i  = r1;
        alloc_rdy2_i  = r2;
    endtask

    task automatic async_reset_check();
        #2 reset_ni = 1'b0;
        #1;
        check("arst_alloc_ready", alloc_ready_o, 1);
        check("arst_iss_valid", iss_valid_o, 0);
        check("arst_count", count_o, 0);
        mq.delete();
        @(negedge clk_i);
        reset_ni = 1'b1;
    endtask

    initial begin
        idle_inputs();
        set_alloc(0, 0, 0, 0, 1'b0, 1'b0);
        alloc_valid_i = 1'b0;
        cdb_tag_i     = '0;
        repeat (3) @(negedge clk_i);
        check("rst_alloc_ready", alloc_ready_o, 1);
        check("rst_iss_valid", iss_valid_o, 0);
        check("rst_count", count_o, 0);
        check("rst_iss_pc", iss_pc_o, 0);
        check("rst_iss_prd", iss_prd_o, 0);
        reset_ni = 1'b1;
        cycle();

        // Single ready ALU op issues the next cycle, then drains.
        set_alloc(int'(FU_ALU), 5, 7, 20, 1'b1, 1'b1);
        cycle();
        alloc_valid_i = 1'b0;
        check("t1_valid", iss_valid_o[0], 1);
        check("t1_prd", iss_prd_o[TW-1:0], 20);
        iss_ready_i = 3'b001;
        cycle();
        check("t1_count", count_o, 0);
        idle_inputs();

        // Younger ready op B overtakes A, A issues after its broadcast.
        set_alloc(int'(FU_ALU), 9, 1, 30, 1'b0, 1'b1);
        cycle();
        set_alloc(int'(FU_ALU), 2, 3, 31, 1'b1, 1'b1);
        cycle();
        alloc_valid_i = 1'b0;
        iss_ready_i   = 3'b001;
        check("t2_b_first", iss_prd_o[TW-1:0], 31);
        cycle();
        check("t2_a_waits", iss_valid_o[0], 0);
        cdb_en_i  = 1'b1;
        cdb_tag_i = 6'd9;
        cycle();
        cdb_en_i = 1'b0;
        check("t2_a_woken", iss_valid_o[0], 1);
        check("t2_a_prd", iss_prd_o[TW-1:0], 30);
        cycle();
        idle_inputs();

        // Both ready: the older one goes first.
        set_alloc(int'(FU_ALU), 1, 2, 32, 1'b1, 1'b1);
        cycle();
        set_alloc(int'(FU_ALU), 3, 4, 33, 1'b1, 1'b1);
        cycle();
        alloc_valid_i = 1'b0;
        iss_ready_i   = 3'b001;
        check("t2b_older", iss_prd_o[TW-1:0], 32);
        cycle();
        check("t2b_younger", iss_prd_o[TW-1:0], 33);
        cycle();
        idle_inputs();

        // Allocation-cycle CDB bypass on src2.
        set_alloc(int'(FU_ALU), 4, 12, 40, 1'b1, 1'b0);
        cdb_en_i  = 1'b1;
        cdb_tag_i = 6'd12;
        cycle();
        idle_inputs();
        check("t3_bypass_valid", iss_valid_o[0], 1);
        check("t3_bypass_prd", iss_prd_o[TW-1:0], 40);
        iss_ready_i = 3'b001;
        cycle();
        idle_inputs();

        // Fill with MUL ops behind a stalled port.
        for (int i = 0; i < DEPTH; i++) begin
            set_alloc(int'(FU_MUL), 16 + i, 24 + i, 48 + i, 1'b1, 1'b1);
            cycle();
        end
        check("t4_full_ready", alloc_ready_o, 0);
        check("t4_full_count", count_o, 8);
        set_alloc(int'(FU_MUL), 1, 1, 63, 1'b1, 1'b1);
        cycle();
        check("t4_extra_ignored", count_o, 8);
        alloc_valid_i = 1'b0;
        iss_ready_i   = 3'b100;
        check("t4_oldest_mul", iss_prd_o[2*TW +: TW], 48);
        cycle();
        iss_ready_i = '0;
        check("t4_after_release", count_o, 7);
        check("t4_ready_again", alloc_ready_o, 1);
        set_alloc(int'(FU_MUL), 1, 1, 60, 1'b1, 1'b1);
        cycle();
        alloc_valid_i = 1'b0;
        check("t4_refill", count_o, 8);
        iss_ready_i = 3'b111;
        repeat (DEPTH) cycle();
        check("t4_drained", count_o, 0);
        idle_inputs();

        // Flush with a concurrent allocation and issue handshakes.
        for (int i = 0; i < 4; i++) begin
            set_alloc(i % NF, i, i + 8, 8 + i, 1'b1, 1'b1);
            cycle();
        end
        set_alloc(int'(FU_LSU), 1, 2, 13, 1'b1, 1'b1);
        iss_ready_i = 3'b111;
        flush_i     = 1'b1;
        cycle();
        idle_inputs();
        check("t5_flush_count", count_o, 0);
        check("t5_flush_valid", iss_valid_o, 0);

        // Random traffic, with one asynchronous reset in the middle.
        for (int n = 0; n < 3000; n++) begin
            alloc_valid_i = ($urandom_range(0, 99) < 60);
            alloc_fu_i    = FUW'($urandom_range(0, NF - 1));
            alloc_pc_i    = $urandom;
            alloc_inst_i  = $urandom;
            alloc_prs1_i  = TW'($urandom_range(0, 15));
            alloc_prs2_i  = TW'($urandom_range(0, 15));
            alloc_prd_i   = TW'($urandom_range(0, 63));
            alloc_rdy1_i  = ($urandom_range(0, 1) == 1);
            alloc_rdy2_i  = ($urandom_range(0, 1) == 1);
            cdb_en_i      = ($urandom_range(0, 99) < 40);
            cdb_tag_i     = TW'($urandom_range(0, 15));
            iss_ready_i   = NF'($urandom_range(0, 7));
            flush_i       = ($urandom_range(0, 99) == 0);
            cycle();
            if (n == 1500) async_reset_check();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
